// File: rtl/img_pkg.sv
// Shared types for the image stream scheduler.
package img_pkg;

  localparam int unsigned WD_RGB = 8;

  typedef enum logic [2:0] {
    IDLE,
    FPRE,
    PIX,
    LBLK,
    FPOST
  } sched_state_t;

  typedef struct packed {
    logic [WD_RGB-1:0] b;
    logic [WD_RGB-1:0] g;
    logic [WD_RGB-1:0] r;
  } rgb888_t;

  // Bits needed to hold values 0..n (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/img_blank_cnt.sv
// Loadable down-counter with a done flag, reused for frame and line blanking.
module img_blank_cnt
  import img_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/img_stream_sched.sv
// Frame/line sequencer: pulls RGB pixels from a valid/ready source and emits
// fsync/vsync/hsync framing with programmable frame and line blanking.
// Optional underrun counter enabled by defining IMG_SCHED_ERR_EN.
module img_stream_sched
  import img_pkg::*;
#(
  parameter int unsigned WD_IMG_DATA  = 8,
  parameter int unsigned W_IMG        = 960,
  parameter int unsigned H_IMG        = 640,
  parameter int unsigned N_FRM_BLANK  = 100,
  parameter int unsigned N_LINE_BLANK = 1,
  parameter int unsigned WD_ERR_INFO  = 4
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_resetn,
  input  logic                     i_cfg_start,
  input  logic                     i_cfg_cont,
  output logic                     o_sched_busy,
  output logic                     o_frame_done,
  input  logic                     s_pix_valid,
  output logic                     s_pix_ready,
  input  logic [3*WD_IMG_DATA-1:0] s_pix_data,
  output logic                     m_img_rgb888_c_fsync,
  output logic                     m_img_rgb888_c_vsync,
  output logic                     m_img_rgb888_c_hsync,
  output logic [WD_IMG_DATA-1:0]   m_img_rgb888_r_mdat0,
  output logic [WD_IMG_DATA-1:0]   m_img_rgb888_g_mdat1,
  output logic [WD_IMG_DATA-1:0]   m_img_rgb888_b_mdat2,
  output logic [WD_ERR_INFO-1:0]   m_err_sched_info1
);

  localparam int unsigned XW = cnt_w(W_IMG - 1);
  localparam int unsigned YW = cnt_w(H_IMG);
  localparam int unsigned BW = cnt_w((N_FRM_BLANK > N_LINE_BLANK) ? N_FRM_BLANK : N_LINE_BLANK);

  localparam logic [XW-1:0] X_LAST    = XW'(W_IMG - 1);
  localparam logic [YW-1:0] Y_END     = YW'(H_IMG);
  localparam logic [BW-1:0] FRM_LOAD  = BW'(N_FRM_BLANK - 1);
  localparam logic [BW-1:0] LINE_LOAD = BW'(N_LINE_BLANK - 1);
  localparam logic [BW-1:0] BLK_ONE   = BW'(1);

  typedef struct packed {
    logic [WD_IMG_DATA-1:0] b;
    logic [WD_IMG_DATA-1:0] g;
    logic [WD_IMG_DATA-1:0] r;
  } pix_t;

  sched_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          fsync_q, fsync_d;
  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic          done_q, done_d;
  pix_t          pix_q, pix_d;

  logic          accept;
  logic          blk_load;
  logic [BW-1:0] blk_val;
  logic          blk_dec;
  logic [BW-1:0] blk_cnt;
  logic          blk_done;

  img_blank_cnt #(
    .W (BW)
  ) u_blank_cnt (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_resetn),
    .load     (blk_load),
    .load_val (blk_val),
    .dec      (blk_dec),
    .cnt      (blk_cnt),
    .done     (blk_done)
  );

  // Next-state, counter control and next values of the registered outputs.
  always_comb begin
    accept   = s_pix_valid && (state_q == PIX);
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    blk_load = 1'b0;
    blk_val  = FRM_LOAD;
    blk_dec  = 1'b0;
    pix_d    = pix_q;
    if (accept) begin
      pix_d = s_pix_data;
    end
    case (state_q)
      IDLE: begin
        if (i_cfg_start) begin
          state_d  = FPRE;
          blk_load = 1'b1;
        end
      end
      FPRE: begin
        if (blk_done) state_d = PIX;
        else          blk_dec = 1'b1;
      end
      PIX: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            state_d  = LBLK;
            x_d      = '0;
            y_d      = y_q + 1'b1;
            blk_load = 1'b1;
            blk_val  = LINE_LOAD;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      LBLK: begin
        if (blk_done) begin
          if (y_q == Y_END) begin
            state_d  = FPOST;
            y_d      = '0;
            blk_load = 1'b1;
          end else begin
            state_d = PIX;
          end
        end else begin
          blk_dec = 1'b1;
        end
      end
      FPOST: begin
        if (blk_done) begin
          if (i_cfg_cont) begin
            state_d  = FPRE;
            blk_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blk_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fsync_d = (state_d == FPRE) || (state_d == PIX) || (state_d == LBLK);
    vsync_d = (state_d == PIX);
    hsync_d = accept;
    // Done marks the last FPOST cycle: counter about to reach zero, or a
    // single-cycle FPOST being entered.
    done_d  = (state_d == FPOST) &&
              ((state_q == FPOST) ? (blk_cnt == BLK_ONE) : (FRM_LOAD == '0));
  end

  // Sequencer state and registered framing/data outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fsync_q <= fsync_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      done_q  <= done_d;
      pix_q   <= pix_d;
    end
  end

`ifdef IMG_SCHED_ERR_EN
  logic [WD_ERR_INFO-1:0] err_q, err_d;

  // Saturating count of PIX cycles without a valid pixel; cleared on FPRE entry.
  always_comb begin
    err_d = err_q;
    if ((state_d == FPRE) && (state_q != FPRE)) begin
      err_d = '0;
    end else if ((state_q == PIX) && !s_pix_valid && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign m_err_sched_info1 = err_q;
`else
  assign m_err_sched_info1 = '0;
`endif

  assign o_sched_busy         = (state_q != IDLE);
  assign o_frame_done         = done_q;
  assign s_pix_ready          = (state_q == PIX);
  assign m_img_rgb888_c_fsync = fsync_q;
  assign m_img_rgb888_c_vsync = vsync_q;
  assign m_img_rgb888_c_hsync = hsync_q;
  assign m_img_rgb888_r_mdat0 = pix_q.r;
  assign m_img_rgb888_g_mdat1 = pix_q.g;
  assign m_img_rgb888_b_mdat2 = pix_q.b;

endmodule
